// File: rtl/standoff_round_ctrl.sv
// standoff_round_ctrl: round sequencer ahead of the outcome calculator.
// Runs countdown -> collection window -> reveal, edge-detects each player's
// one-hot buttons, locks the first valid press and presents stable choices
// during the reveal window.
// Optional feature: define AMMO_TRACK_EN to enable per-player ammo tracking
// (SHOOT gated by ammo, RELOAD refills up to MAX_AMMO).
module standoff_round_ctrl #(
  parameter int unsigned TICK_DIV      = 50_000_000,
  parameter int unsigned COUNT_TICKS   = 3,
  parameter int unsigned COLLECT_TICKS = 2,
  parameter int unsigned REVEAL_CYCLES = 4,
  parameter int unsigned MAX_AMMO      = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] p1_btn,
  input  logic [3:0] p2_btn,
  output logic [3:0] p1_choice,
  output logic [3:0] p2_choice,
  output logic       reveal_valid,
  output logic       collect_open,
  output logic [3:0] countdown,
  output logic       p1_locked,
  output logic       p2_locked,
  output logic [7:0] round_num,
  output logic [1:0] p1_ammo,
  output logic [1:0] p2_ammo
);

`ifdef AMMO_TRACK_EN
  localparam bit AMMO_EN = 1'b1;
`else
  localparam bit AMMO_EN = 1'b0;
`endif

  localparam logic [3:0] C_RELOAD = 4'b1000;
  localparam logic [3:0] C_SHOOT  = 4'b0100;
  localparam logic [3:0] C_WAIT   = 4'b0010;
  localparam logic [3:0] C_DODGE  = 4'b0001;

  // One counter serves both the tick divider and the reveal hold.
  localparam int unsigned CNT_MAX = (TICK_DIV > REVEAL_CYCLES) ? TICK_DIV : REVEAL_CYCLES;
  localparam int unsigned TW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned CW      = (COLLECT_TICKS > 1) ? $clog2(COLLECT_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] REV_LAST  = TW'(REVEAL_CYCLES - 1);
  localparam logic [CW-1:0] COLL_LAST = CW'(COLLECT_TICKS - 1);
  localparam logic [1:0]    AMMO_CAP  = 2'(MAX_AMMO);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COUNTDOWN,
    S_COLLECT,
    S_REVEAL
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [CW-1:0] coll_q, coll_d;
  logic [3:0]    p1_prev_q, p1_prev_d, p2_prev_q, p2_prev_d;
  logic [3:0]    p1_code_q, p1_code_d, p2_code_q, p2_code_d;
  logic [3:0]    p1_choice_q, p1_choice_d, p2_choice_q, p2_choice_d;
  logic          reveal_valid_q, reveal_valid_d;
  logic          collect_open_q, collect_open_d;
  logic [3:0]    countdown_q, countdown_d;
  logic          p1_locked_q, p1_locked_d, p2_locked_q, p2_locked_d;
  logic [7:0]    round_num_q, round_num_d;
  logic [1:0]    p1_ammo_q, p1_ammo_d, p2_ammo_q, p2_ammo_d;

  logic [3:0]    p1_press, p2_press;
  logic          p1_acc, p2_acc;
  logic [3:0]    p1_final, p2_final;

  // True for exactly one of the four legal one-hot codes.
  function automatic logic is_code(input logic [3:0] v);
    return (v == C_RELOAD) || (v == C_SHOOT) || (v == C_WAIT) || (v == C_DODGE);
  endfunction

  // SHOOT needs ammo only when tracking is enabled.
  function automatic logic can_take(input logic [3:0] v, input logic [1:0] ammo);
    return is_code(v) && ((v != C_SHOOT) || !AMMO_EN || (ammo != 2'd0));
  endfunction

  // Ammo after the revealed choice: SHOOT spends, RELOAD refills to the cap.
  function automatic logic [1:0] next_ammo(input logic [1:0] ammo, input logic [3:0] code);
    logic [1:0] res;
    res = ammo;
    if (!AMMO_EN) begin
      res = 2'd0;
    end else if ((code == C_SHOOT) && (ammo != 2'd0)) begin
      res = ammo - 2'd1;
    end else if ((code == C_RELOAD) && (ammo < AMMO_CAP)) begin
      res = ammo + 2'd1;
    end
    return res;
  endfunction

  // Rising-edge press detection and acceptance for both players.
  always_comb begin
    p1_press = p1_btn & ~p1_prev_q;
    p2_press = p2_btn & ~p2_prev_q;
    p1_acc   = (state_q == S_COLLECT) && !p1_locked_q && can_take(p1_press, p1_ammo_q);
    p2_acc   = (state_q == S_COLLECT) && !p2_locked_q && can_take(p2_press, p2_ammo_q);
    p1_final = p1_acc ? p1_press : (p1_locked_q ? p1_code_q : 4'b0000);
    p2_final = p2_acc ? p2_press : (p2_locked_q ? p2_code_q : 4'b0000);
  end

  // Round sequencer: next state and all registered outputs.
  always_comb begin
    state_d        = state_q;
    tick_d         = tick_q;
    coll_d         = coll_q;
    p1_prev_d      = p1_btn;
    p2_prev_d      = p2_btn;
    p1_code_d      = p1_code_q;
    p2_code_d      = p2_code_q;
    p1_choice_d    = p1_choice_q;
    p2_choice_d    = p2_choice_q;
    reveal_valid_d = reveal_valid_q;
    collect_open_d = collect_open_q;
    countdown_d    = countdown_q;
    p1_locked_d    = p1_locked_q;
    p2_locked_d    = p2_locked_q;
    round_num_d    = round_num_q;
    p1_ammo_d      = p1_ammo_q;
    p2_ammo_d      = p2_ammo_q;

    if (p1_acc) begin
      p1_code_d   = p1_press;
      p1_locked_d = 1'b1;
    end
    if (p2_acc) begin
      p2_code_d   = p2_press;
      p2_locked_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_COUNTDOWN;
          countdown_d = 4'(COUNT_TICKS);
          tick_d      = '0;
          coll_d      = '0;
          p1_locked_d = 1'b0;
          p2_locked_d = 1'b0;
          p1_code_d   = 4'b0000;
          p2_code_d   = 4'b0000;
        end
      end

      S_COUNTDOWN: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (countdown_q <= 4'd1) begin
            state_d        = S_COLLECT;
            countdown_d    = 4'd0;
            collect_open_d = 1'b1;
          end else begin
            countdown_d = countdown_q - 4'd1;
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      S_COLLECT: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (coll_q == COLL_LAST) begin
            state_d        = S_REVEAL;
            collect_open_d = 1'b0;
            reveal_valid_d = 1'b1;
            p1_choice_d    = p1_final;
            p2_choice_d    = p2_final;
            p1_ammo_d      = next_ammo(p1_ammo_q, p1_final);
            p2_ammo_d      = next_ammo(p2_ammo_q, p2_final);
          end else begin
            coll_d = coll_q + CW'(1);
          end
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      S_REVEAL: begin
        if (tick_q == REV_LAST) begin
          state_d        = S_IDLE;
          tick_d         = '0;
          reveal_valid_d = 1'b0;
          p1_choice_d    = 4'b0000;
          p2_choice_d    = 4'b0000;
          p1_locked_d    = 1'b0;
          p2_locked_d    = 1'b0;
          round_num_d    = round_num_q + 8'd1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      tick_q         <= '0;
      coll_q         <= '0;
      p1_prev_q      <= 4'b0000;
      p2_prev_q      <= 4'b0000;
      p1_code_q      <= 4'b0000;
      p2_code_q      <= 4'b0000;
      p1_choice_q    <= 4'b0000;
      p2_choice_q    <= 4'b0000;
      reveal_valid_q <= 1'b0;
      collect_open_q <= 1'b0;
      countdown_q    <= 4'd0;
      p1_locked_q    <= 1'b0;
      p2_locked_q    <= 1'b0;
      round_num_q    <= 8'd0;
      p1_ammo_q      <= 2'd0;
      p2_ammo_q      <= 2'd0;
    end else begin
      state_q        <= state_d;
      tick_q         <= tick_d;
      coll_q         <= coll_d;
      p1_prev_q      <= p1_prev_d;
      p2_prev_q      <= p2_prev_d;
      p1_code_q      <= p1_code_d;
      p2_code_q      <= p2_code_d;
      p1_choice_q    <= p1_choice_d;
      p2_choice_q    <= p2_choice_d;
      reveal_valid_q <= reveal_valid_d;
      collect_open_q <= collect_open_d;
      countdown_q    <= countdown_d;
      p1_locked_q    <= p1_locked_d;
      p2_locked_q    <= p2_locked_d;
      round_num_q    <= round_num_d;
      p1_ammo_q      <= p1_ammo_d;
      p2_ammo_q      <= p2_ammo_d;
    end
  end

  assign p1_choice    = p1_choice_q;
  assign p2_choice    = p2_choice_q;
  assign reveal_valid = reveal_valid_q;
  assign collect_open = collect_open_q;
  assign countdown    = countdown_q;
  assign p1_locked    = p1_locked_q;
  assign p2_locked    = p2_locked_q;
  assign round_num    = round_num_q;
  assign p1_ammo      = p1_ammo_q;
  assign p2_ammo      = p2_ammo_q;

endmodule

// File: tb/tb_standoff_round_ctrl.sv
// Bench for standoff_round_ctrl with TICK_DIV=4, COUNT_TICKS=3,
// COLLECT_TICKS=2, REVEAL_CYCLES=4. Cycle c of a round: start is sampled
// at the end of cycle 0, COUNTDOWN is 1-12, COLLECT 13-20, REVEAL 21-24,
// IDLE again at 25.
module tb_standoff_round_ctrl;

`ifdef AMMO_TRACK_EN
  localparam bit AMMO_EN = 1'b1;
`else
  localparam bit AMMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] p1_btn, p2_btn;
  logic [3:0] p1_choice, p2_choice;
  logic       reveal_valid, collect_open;
  logic [3:0] countdown;
  logic       p1_locked, p2_locked;
  logic [7:0] round_num;
  logic [1:0] p1_ammo, p2_ammo;

  int checks   = 0;
  int failures = 0;
  int rn       = 0;

  standoff_round_ctrl #(
    .TICK_DIV(4), .COUNT_TICKS(3), .COLLECT_TICKS(2), .REVEAL_CYCLES(4), .MAX_AMMO(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .p1_btn(p1_btn), .p2_btn(p2_btn),
    .p1_choice(p1_choice), .p2_choice(p2_choice), .reveal_valid(reveal_valid),
    .collect_open(collect_open), .countdown(countdown), .p1_locked(p1_locked),
    .p2_locked(p2_locked), .round_num(round_num), .p1_ammo(p1_ammo), .p2_ammo(p2_ammo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         p1_c1;
    logic [3:0] p1_v1;
    int         p1_c2;
    logic [3:0] p1_v2;
    int         p1_hold;
    int         p2_c;
    logic [3:0] p2_v;
    logic [3:0] e1;
    logic [3:0] e2;
    logic       l1;
    logic       l2;
    logic [1:0] ea1;
    int         abort;
  } rec_t;

  function automatic rec_t mk(input int p1_c1, input logic [3:0] p1_v1, input int p1_c2,
                              input logic [3:0] p1_v2, input int p1_hold, input int p2_c,
                              input logic [3:0] p2_v, input logic [3:0] e1, input logic [3:0] e2,
                              input logic l1, input logic l2, input logic [1:0] ea1, input int abort);
    rec_t r;
    r.p1_c1 = p1_c1; r.p1_v1 = p1_v1; r.p1_c2 = p1_c2; r.p1_v2 = p1_v2;
    r.p1_hold = p1_hold; r.p2_c = p2_c; r.p2_v = p2_v; r.e1 = e1; r.e2 = e2;
    r.l1 = l1; r.l2 = l2; r.ea1 = ea1; r.abort = abort;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int c, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, c, act, exp);
    end
  endtask

  function automatic int exp_cd(input int c);
    return (c == 13) ? 0 : 3 - (c - 1) / 4;
  endfunction

  // Run one round from IDLE, driving the record's presses and checking outputs.
  task automatic run_round(input rec_t r);
    for (int c = 0; c <= 25; c++) begin
      start = (c == 0);
      if (r.p1_hold >= 0 && c >= r.p1_hold && c <= 24) p1_btn = r.p1_v1;
      else if (c == r.p1_c1) p1_btn = r.p1_v1;
      else if (c == r.p1_c2) p1_btn = r.p1_v2;
      else p1_btn = 4'b0000;
      p2_btn = (c == r.p2_c) ? r.p2_v : 4'b0000;

      if (c >= 1 && c <= 13) chk("countdown", c, 8'(countdown), 8'(exp_cd(c)));
      if (c == 12) chk("collect_open_pre", c, 8'(collect_open), 8'd0);
      if (c == 13) chk("collect_open", c, 8'(collect_open), 8'd1);
      if (c == 20) begin
        chk("choice_pre_reveal", c, 8'(p1_choice), 8'd0);
        chk("reveal_pre", c, 8'(reveal_valid), 8'd0);
      end
      if (c == 21) begin
        chk("reveal_valid", c, 8'(reveal_valid), 8'd1);
        chk("collect_closed", c, 8'(collect_open), 8'd0);
        chk("p1_choice", c, 8'(p1_choice), 8'(r.e1));
        chk("p2_choice", c, 8'(p2_choice), 8'(r.e2));
        chk("p1_locked", c, 8'(p1_locked), 8'(r.l1));
        chk("p2_locked", c, 8'(p2_locked), 8'(r.l2));
        chk("p1_ammo", c, 8'(p1_ammo), 8'(r.ea1));
      end
      if (c == 22 && r.abort == 22) begin
        reset = 1'b1;
        tick();
        chk("rst_reveal", 23, 8'(reveal_valid), 8'd0);
        chk("rst_p1_choice", 23, 8'(p1_choice), 8'd0);
        chk("rst_p1_locked", 23, 8'(p1_locked), 8'd0);
        chk("rst_countdown", 23, 8'(countdown), 8'd0);
        chk("rst_round_num", 23, round_num, 8'(rn));
        reset = 1'b0;
        return;
      end
      if (c == 24) begin
        chk("reveal_hold", c, 8'(reveal_valid), 8'd1);
        chk("p1_choice_hold", c, 8'(p1_choice), 8'(r.e1));
        chk("p2_choice_hold", c, 8'(p2_choice), 8'(r.e2));
      end
      if (c == 25) begin
        chk("reveal_end", c, 8'(reveal_valid), 8'd0);
        chk("p1_choice_end", c, 8'(p1_choice), 8'd0);
        chk("p2_choice_end", c, 8'(p2_choice), 8'd0);
        chk("p1_locked_end", c, 8'(p1_locked), 8'd0);
        chk("round_num", c, round_num, 8'(rn + 1));
      end
      tick();
    end
    rn++;
  endtask

  rec_t tbl[6];
  rec_t ammo_tbl[5];
  rec_t abort_rec;

  initial begin
    // basic: p1 SHOOT@15, p2 RELOAD@17
    tbl[0] = mk(15, 4'b0100, -1, 4'b0000, -1, 17, 4'b1000,
                AMMO_EN ? 4'b0000 : 4'b0100, 4'b1000, !AMMO_EN, 1'b1, 2'd0, -1);
    // p1 holds WAIT from countdown; no fresh edge in COLLECT
    tbl[1] = mk(-1, 4'b0010, -1, 4'b0000, 5, -1, 4'b0000,
                4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, -1);
    // first press locks, later press ignored; p2 invalid pattern
    tbl[2] = mk(14, 4'b0001, 16, 4'b1000, -1, 15, 4'b0110,
                4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, -1);
    // last COLLECT cycle (p1) and first COLLECT cycle (p2)
    tbl[3] = mk(20, 4'b0010, -1, 4'b0000, -1, 13, 4'b0001,
                4'b0010, 4'b0001, 1'b1, 1'b1, 2'd0, -1);
    // press in last countdown cycle and during reveal are ignored
    tbl[4] = mk(12, 4'b1000, -1, 4'b0000, -1, 21, 4'b0100,
                4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, -1);
    // both players in the same cycle
    tbl[5] = mk(18, 4'b1000, -1, 4'b0000, -1, 18, 4'b0010,
                4'b1000, 4'b0010, 1'b1, 1'b1, AMMO_EN ? 2'd1 : 2'd0, -1);

    abort_rec = mk(15, 4'b0010, -1, 4'b0000, -1, -1, 4'b0000,
                   4'b0010, 4'b0000, 1'b1, 1'b0, 2'd0, 22);

    ammo_tbl[0] = mk(15, 4'b0100, -1, 4'b0000, -1, -1, 4'b0000,
                     4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, -1);
    ammo_tbl[1] = mk(15, 4'b1000, -1, 4'b0000, -1, -1, 4'b0000,
                     4'b1000, 4'b0000, 1'b1, 1'b0, 2'd1, -1);
    ammo_tbl[2] = mk(15, 4'b0100, -1, 4'b0000, -1, -1, 4'b0000,
                     4'b0100, 4'b0000, 1'b1, 1'b0, 2'd0, -1);
    ammo_tbl[3] = mk(15, 4'b1000, -1, 4'b0000, -1, -1, 4'b0000,
                     4'b1000, 4'b0000, 1'b1, 1'b0, 2'd1, -1);
    ammo_tbl[4] = mk(15, 4'b1000, -1, 4'b0000, -1, -1, 4'b0000,
                     4'b1000, 4'b0000, 1'b1, 1'b0, 2'd1, -1);

    reset = 1'b1; start = 1'b0; p1_btn = 4'b0000; p2_btn = 4'b0000;
    tick();
    tick();
    chk("reset_countdown", 0, 8'(countdown), 8'd0);
    chk("reset_reveal", 0, 8'(reveal_valid), 8'd0);
    chk("reset_collect", 0, 8'(collect_open), 8'd0);
    chk("reset_choices", 0, 8'({p1_choice, p2_choice}), 8'd0);
    chk("reset_locks", 0, 8'({p1_locked, p2_locked}), 8'd0);
    chk("reset_round_num", 0, round_num, 8'd0);
    chk("reset_ammo", 0, 8'({p1_ammo, p2_ammo}), 8'd0);
    reset = 1'b0;

    // reset during REVEAL, then normal rounds from the table
    run_round(abort_rec);
    for (int i = 0; i < 6; i++) run_round(tbl[i]);

    // start held high: ignored mid-round, relaunches immediately on IDLE
    p1_btn = 4'b0000; p2_btn = 4'b0000;
    for (int c = 0; c <= 50; c++) begin
      start = (c < 26);
      if (c == 5)  chk("held_start_countdown", c, 8'(countdown), 8'd2);
      if (c == 21) chk("held_start_reveal", c, 8'(reveal_valid), 8'd1);
      if (c == 25) chk("held_start_round", c, round_num, 8'(rn + 1));
      if (c == 26) chk("relaunch_countdown", c, 8'(countdown), 8'd3);
      if (c == 50) chk("relaunch_round", c, round_num, 8'(rn + 2));
      tick();
    end
    rn += 2;
    start = 1'b0;

`ifdef AMMO_TRACK_EN
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rn = 0;
    chk("ammo_reset", 0, 8'(p1_ammo), 8'd0);
    for (int i = 0; i < 5; i++) run_round(ammo_tbl[i]);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/standoff_round_ctrl.md
Name: standoff_round_ctrl

Overview:
- Round sequencer directly upstream of the outcome calculator.
- Runs countdown → choice-collection window → reveal for each round.
- Edge-detects each player's 4 one-hot buttons and locks the first valid press.
- Drives stable one-hot p1_choice/p2_choice to the outcome stage during the reveal window.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per game tick (1 s at 50 MHz).
- COUNT_TICKS, 3: ticks in countdown, range 1..15.
- COLLECT_TICKS, 2: ticks in collection window.
- REVEAL_CYCLES, 4: clk cycles choices are held valid, ≥2 (outcome stage registers on clk).
- MAX_AMMO, 1: ammo cap, used only with AMMO_TRACK_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level; begins a round when sampled high in IDLE
- p1_btn  in  4  player 1 buttons, pre-synchronised/debounced, level
- p2_btn  in  4  player 2 buttons, same encoding
- p1_choice  out  4  one-hot choice to outcome stage, 4'b0000 = none
- p2_choice  out  4  same for player 2
- reveal_valid  out  1  high while choices are driven
- collect_open  out  1  high during collection window
- countdown  out  4  remaining countdown ticks for display
- p1_locked  out  1  player 1 choice locked this round
- p2_locked  out  1  player 2 choice locked this round
- round_num  out  8  completed-round count
- p1_ammo  out  2  ammo count (0 when feature disabled)
- p2_ammo  out  2  ammo count (0 when feature disabled)

Behaviour:
- Encoding:
  - 4'b1000 RELOAD, 4'b0100 SHOOT, 4'b0010 WAIT, 4'b0001 DODGE.
  - Any other button pattern in a press cycle is invalid and ignored.
- All outputs are registered.
- Reset forces state IDLE and sets every output to 0, including round_num and ammo. Also clears tick counter, locks, and button history.
- States: IDLE, COUNTDOWN, COLLECT, REVEAL.
  - IDLE: start=1 → COUNTDOWN next edge. Load countdown=COUNT_TICKS; clear tick counter, locks, and locked choices.
  - COUNTDOWN: tick counter runs 0..TICK_DIV-1.
    - countdown decrements on each wrap.
    - When countdown would reach 0 → COLLECT. countdown reads 0; collect_open=1.
    - Total COUNT_TICKS*TICK_DIV cycles.
  - COLLECT: lasts COLLECT_TICKS*TICK_DIV cycles, then → REVEAL.
  - REVEAL: lasts REVEAL_CYCLES cycles, then → IDLE with round_num += 1 (wraps 255 → 0).
- start while not IDLE is ignored. start held high re-launches a round immediately on return to IDLE.
- Press detection:
  - A press is btn & ~btn_prev per player.
  - btn_prev updates every cycle in every state, so a button held from countdown does not count until released and re-pressed.
  - A press is accepted only when the current state is COLLECT, the player is not yet locked, and the press vector is a valid one-hot code.
  - An accepted press latches the code and sets pX_locked the next cycle.
  - Later presses are ignored.
  - A press on the last COLLECT cycle is accepted.
  - Both players pressing in the same cycle: both accepted independently.
- Reveal:
  - On the edge entering REVEAL, pX_choice takes the latched code, or 4'b0000 if not locked, and reveal_valid=1.
  - Held stable for exactly REVEAL_CYCLES cycles.
  - Cleared to 0 on the edge leaving REVEAL.
  - pX_locked clears on the edge leaving REVEAL.
  - p1_choice/p2_choice are 4'b0000 in every state except REVEAL.
- Reset mid-round: immediate return to IDLE with all outputs 0. No partial choice reaches the outcome stage.

Optional Feature:
- Macro: AMMO_TRACK_EN.
- Enabled:
  - Per-player 2-bit ammo counter.
  - A SHOOT press is accepted only if ammo > 0. A rejected SHOOT leaves the player unlocked, so another press is still possible.
  - On REVEAL entry: locked SHOOT decrements ammo; locked RELOAD increments ammo, saturating at MAX_AMMO.
  - Ammo persists across rounds; reset clears it to 0.
- Disabled:
  - SHOOT is always accepted.
  - p1_ammo/p2_ammo are tied to 0.

Test Plan:
All scenarios use TICK_DIV=4, COUNT_TICKS=3, COLLECT_TICKS=2, REVEAL_CYCLES=4.

1. Basic round: start pulse at cycle 0; p1_btn=0100 at cycle 15; p2_btn=1000 at cycle 17 → COLLECT occupies cycles 13-20. During cycles 21-24, p1_choice=0100, p2_choice=1000, reveal_valid=1. At cycle 25 all cleared and round_num=1.
2. Countdown display: after start, countdown reads 3, 2, 1 for 4 cycles each, then 0 with collect_open=1.
3. Held/early press: p1 holds 0010 from cycle 5 through COLLECT; p2 presses nothing → reveal shows p1_choice=0000, p2_choice=0000, p1_locked=0.
4. Lock and invalid patterns: p1 presses 0001 at cycle 14, then 1000 at cycle 16; p2 presses 0110 → p1_choice=0001, p2_choice=0000.
5. Reset at cycle 22 during REVEAL → next cycle all outputs 0, state IDLE, round_num unchanged from 0. A subsequent start runs a normal round.
6. AMMO_TRACK_EN: round 1 p1 SHOOT with ammo 0 → rejected, choice 0000. Round 2 p1 RELOAD → ammo=1. Round 3 p1 SHOOT → p1_choice=0100, ammo=0. Two RELOADs with MAX_AMMO=1 → ammo stays 1.
